rep_det_banked: RTL and testbench
=================================

// Module: rep_det_banked
// PURPOSE
//  Banked, parametrised threefold-repetition detector for the search pipeline. Holds the game/search
//  history in LANES interleaved RAM banks. It scans newest-to-oldest, LANES entries per cycle, and
//  counts only same-side-to-move positions inside the halfmove-clock window. It exits early once
//  REP_THRESHOLD prior matches are found. Result is held for the evaluator until clear_sample.
// PARAMETERS
//  REPDET_WIDTH   8  log2 history entries; history index/depth width
//  LANES          2  banks = entries compared per scan cycle; power of 2, 1..8
//  REP_THRESHOLD  2  prior matches required for thrice_rep (2 => third occurrence)
// PORTS
//  clk                 in   1                   clock
//  reset               in   1                   asynchronous, active-high reset
//  board_in            in   `BOARD_WIDTH        position under test
//  castle_mask_in      in   4                   castle rights of position under test
//  halfmove_in         in   REPDET_WIDTH        plies since last capture/pawn move (window size)
//  board_valid         in   1                   start request; sampled only in IDLE
//  clear_sample        in   1                   DONE -> IDLE; result consumed
//  ram_board_in        in   `BOARD_WIDTH        history write data
//  ram_castle_mask_in  in   4                   history write data
//  ram_wr_addr_in      in   REPDET_WIDTH        history write index
//  ram_wr_en           in   1                   history write strobe, any state
//  ram_depth_in        in   REPDET_WIDTH        ply index of position under test (= entries in use)
//  busy                out  1                   high in any state but IDLE
//  rep_count           out  REPDET_WIDTH+1      matches found, saturates at REP_THRESHOLD
//  thrice_rep          out  1                   rep_count == REP_THRESHOLD
//  thrice_rep_valid    out  1                   high only in DONE
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy, rep_count, thrice_rep, thrice_rep_valid = 0. RAM not cleared.
//  - Key = {castle_mask, board}, RAM_WIDTH = `BOARD_WIDTH+4. Entry idx lives in bank idx%LANES,
//    row idx/LANES. Reads are registered, 1-cycle latency. Simultaneous read/write of the same entry
//    returns old data.
//  - IDLE: on board_valid, latch key, depth D, lo = (halfmove_in >= D) ? 0 : D-halfmove_in.
//    Candidates: idx in [lo, D-1] with (D-idx) even (same side to move). If D-lo < 2, go to DONE
//    on the next edge with count 0. Otherwise go to SCAN.
//  - SCAN: group g (g=0..G-1, G=ceil((D-lo)/LANES)) covers idx D-1-g*LANES down to D-g*LANES-LANES.
//    Lanes with idx<lo or odd (D-idx) are masked. One group is issued per cycle, pipelined:
//    issue -> RAM read -> compare/popcount -> accumulate. Accumulator width REPDET_WIDTH+1 saturates
//    at REP_THRESHOLD.
//  - No early exit: DONE is entered G+3 edges after the acceptance edge.
//  - Early exit: on the edge where the accumulator reaches REP_THRESHOLD, stop issuing, discard
//    in-flight groups, and enter DONE on the next edge.
//  - DONE: rep_count, thrice_rep and thrice_rep_valid=1 are held stable. clear_sample -> IDLE next
//    edge, and valid/thrice_rep drop there. board_valid is ignored outside IDLE.
//  - Writes into [lo, D-1] during SCAN are performed, but that scan's result is undefined (caller
//    contract). Writes outside the range do not disturb the result.
//  - D=0: no candidates -> count 0. Depth index arithmetic is modulo 2^REPDET_WIDTH, with no
//    wrap of history.
// TESTING  (REPDET_WIDTH=4, LANES=2, REP_THRESHOLD=2)
//  1 D=0, board_valid -> busy 1 edge, then thrice_rep_valid=1, rep_count=0, thrice_rep=0.
//  2 key A at idx 0,2,4; D=6, halfmove 10, query A -> rep_count=2, thrice_rep=1, early exit
//    before G+3=6 edges.
//  3 A at idx 1,3,5 only (odd offsets); D=6, query A -> rep_count=0, valid 6 edges after accept.
//  4 A at idx 0,4; D=6, halfmove 3 (lo=3) -> rep_count=1, thrice_rep=0, valid 5 edges after accept.
//  5 A at 2,4 but castle mask differs from query -> rep_count=0. Then clear_sample -> IDLE, valid=0.
//  6 reset pulse mid-SCAN -> outputs 0 immediately, IDLE. New request afterwards returns the
//    correct result.

Source files
------------

// File: rtl/rep_det_banked.sv
// rep_det_banked: banked threefold-repetition detector scanning LANES history entries per cycle,
// newest to oldest, with saturation and early exit at REP_THRESHOLD prior matches.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module rep_det_banked #(
    parameter int REPDET_WIDTH  = 8,
    parameter int LANES         = 2,
    parameter int REP_THRESHOLD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [`BOARD_WIDTH-1:0] board_in,
    input  logic [3:0]              castle_mask_in,
    input  logic [REPDET_WIDTH-1:0] halfmove_in,
    input  logic                    board_valid,
    input  logic                    clear_sample,
    input  logic [`BOARD_WIDTH-1:0] ram_board_in,
    input  logic [3:0]              ram_castle_mask_in,
    input  logic [REPDET_WIDTH-1:0] ram_wr_addr_in,
    input  logic                    ram_wr_en,
    input  logic [REPDET_WIDTH-1:0] ram_depth_in,
    output logic                    busy,
    output logic [REPDET_WIDTH:0]   rep_count,
    output logic                    thrice_rep,
    output logic                    thrice_rep_valid
);
    localparam int W    = REPDET_WIDTH;
    localparam int KW   = `BOARD_WIDTH + 4;
    localparam int LB   = $clog2(LANES);
    localparam int BKW  = (LB > 0) ? LB : 1;
    localparam int RW   = W - LB;
    localparam int ROWS = 1 << RW;
    localparam logic [W:0] THR = (W+1)'(REP_THRESHOLD);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    key_q, key_d;
    logic [W-1:0]     dep_q, dep_d, lo_q, lo_d, n, idx;
    logic [W:0]       g_q, g_d, acc_q, acc_d, pc_q, pc_d, grp;
    logic [W+1:0]     cnt_q, cnt_d, sum, off;
    logic             rd_v_q, pc_v_q, issue;
    logic [BKW-1:0]   bnk, bnk_c;
    logic [LANES-1:0] mask_q, mask_d;
    logic [KW-1:0]    mem [LANES][ROWS];
    logic [KW-1:0]    rdata_q [LANES];
    logic [RW-1:0]    raddr [LANES];

    // Lane l of group g looks at offset D-idx = g*LANES+l+1; offsets are used for masking so
    // nothing depends on the wrapped index.
    always_comb begin
        n     = dep_q - lo_q;
        grp   = ({1'b0, n} + (W+1)'(LANES - 1)) >> LB;
        issue = state_q == SCAN && n >= W'(2) && g_q < grp && acc_q < THR;
        mask_d = '0;
        off    = '0;
        idx    = '0;
        bnk    = '0;
        for (int i = 0; i < LANES; i++) raddr[i] = '0;
        for (int l = 0; l < LANES; l++) begin
            off       = ({1'b0, g_q} << LB) + (W+2)'(l + 1);
            idx       = dep_q - W'(off);
            bnk       = BKW'(idx % LANES);
            mask_d[l] = issue && off <= {2'b0, n} && !off[0];
            raddr[bnk] = RW'(idx >> LB);
        end
    end

    // Lane-to-bank mapping is fixed for the whole scan since every group shifts by LANES.
    always_comb begin
        pc_d  = '0;
        bnk_c = '0;
        for (int l = 0; l < LANES; l++) begin
            bnk_c = BKW'((dep_q - W'(l + 1)) % LANES);
            pc_d  = pc_d + (W+1)'(mask_q[l] && rdata_q[bnk_c] == key_q);
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        dep_d   = dep_q;
        lo_d    = lo_q;
        g_d     = issue ? g_q + (W+1)'(1) : g_q;
        cnt_d   = cnt_q + (W+2)'(1);
        sum     = {1'b0, acc_q} + {1'b0, pc_q};
        acc_d   = (state_q == SCAN && pc_v_q) ? ((sum >= {1'b0, THR}) ? THR : sum[W:0]) : acc_q;
        if (state_q == IDLE && board_valid) begin
            key_d   = {castle_mask_in, board_in};
            dep_d   = ram_depth_in;
            lo_d    = (halfmove_in >= ram_depth_in) ? '0 : ram_depth_in - halfmove_in;
            g_d     = '0;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = SCAN;
        end else if (state_q == SCAN && (n < W'(2) || acc_q == THR || cnt_q == {1'b0, grp} + (W+2)'(2)))
            state_d = DONE;
        else if (state_q == DONE && clear_sample)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            dep_q   <= '0;
            lo_q    <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            pc_q    <= '0;
            rd_v_q  <= 1'b0;
            pc_v_q  <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            dep_q   <= dep_d;
            lo_q    <= lo_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            pc_q    <= pc_d;
            rd_v_q  <= issue;
            pc_v_q  <= rd_v_q && state_q == SCAN;
            mask_q  <= mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_wr_en)
            mem[BKW'(ram_wr_addr_in % LANES)][RW'(ram_wr_addr_in >> LB)] <= {ram_castle_mask_in, ram_board_in};
        for (int b = 0; b < LANES; b++) rdata_q[b] <= mem[b][raddr[b]];
    end

    assign busy             = state_q != IDLE;
    assign thrice_rep_valid = state_q == DONE;
    assign thrice_rep       = state_q == DONE && acc_q == THR;
    assign rep_count        = acc_q;
endmodule

// File: tb/tb_rep_det_banked.sv
// tb_rep_det_banked: directed scenarios with a result scoreboard for rep_det_banked
// (REPDET_WIDTH=4, LANES=2, REP_THRESHOLD=2).
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_rep_det_banked;
    localparam int W  = 4;
    localparam int BW = `BOARD_WIDTH;
    localparam logic [3:0]    CM_A  = 4'h5;
    localparam logic [BW-1:0] BRD_A = BW'(64'hDEAD_BEEF_0000_0001);

    logic          clk = 1'b0, reset = 1'b1;
    logic [BW-1:0] board_in = '0, ram_board_in = '0;
    logic [3:0]    castle_mask_in = '0, ram_castle_mask_in = '0;
    logic [W-1:0]  halfmove_in = '0, ram_wr_addr_in = '0, ram_depth_in = '0;
    logic          board_valid = 1'b0, clear_sample = 1'b0, ram_wr_en = 1'b0;
    logic          busy, thrice_rep, thrice_rep_valid;
    logic [W:0]    rep_count;

    typedef struct {
        logic [W:0] cnt;
        logic       thr;
        int         lo_lat;
        int         hi_lat;
    } exp_t;
    exp_t sb[$];

    int pass_cnt = 0, fail_cnt = 0, total = 0;

    rep_det_banked #(.REPDET_WIDTH(W), .LANES(2), .REP_THRESHOLD(2)) dut (
        .clk(clk), .reset(reset), .board_in(board_in), .castle_mask_in(castle_mask_in),
        .halfmove_in(halfmove_in), .board_valid(board_valid), .clear_sample(clear_sample),
        .ram_board_in(ram_board_in), .ram_castle_mask_in(ram_castle_mask_in),
        .ram_wr_addr_in(ram_wr_addr_in), .ram_wr_en(ram_wr_en), .ram_depth_in(ram_depth_in),
        .busy(busy), .rep_count(rep_count), .thrice_rep(thrice_rep),
        .thrice_rep_valid(thrice_rep_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int i, input logic [3:0] cm, input logic [BW-1:0] b);
        @(negedge clk);
        ram_wr_addr_in     = W'(i);
        ram_castle_mask_in = cm;
        ram_board_in       = b;
        ram_wr_en          = 1'b1;
        @(negedge clk);
        ram_wr_en = 1'b0;
    endtask

    task automatic filler(input int i);
        wr(i, CM_A, BW'(64'hF000) + BW'(i));
    endtask

    task automatic start(input int d, input int hm, input logic [3:0] cm, input logic [BW-1:0] b);
        @(negedge clk);
        ram_depth_in   = W'(d);
        halfmove_in    = W'(hm);
        castle_mask_in = cm;
        board_in       = b;
        board_valid    = 1'b1;
        @(posedge clk);
        #1 board_valid = 1'b0;
    endtask

    task automatic query(input string tag, input int d, input int hm, input logic [3:0] cm,
                         input int ec, input int lo, input int hi);
        exp_t e;
        int   edges;
        logic [W:0] held;
        sb.push_back('{cnt: (W+1)'(ec), thr: ec == 2, lo_lat: lo, hi_lat: hi});
        start(d, hm, cm, BRD_A);
        chk({tag, "_busy"}, 32'(busy), 1);
        edges = 0;
        while (!thrice_rep_valid && edges < 40) begin
            @(posedge clk);
            #1 edges++;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, 32'(thrice_rep_valid), 1);
        chk({tag, "_count"}, 32'(rep_count), 32'(e.cnt));
        chk({tag, "_thrice"}, 32'(thrice_rep), 32'(e.thr));
        total++;
        assert (edges >= e.lo_lat && edges <= e.hi_lat) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s_latency: got %0d edges expected %0d..%0d", tag, edges, e.lo_lat, e.hi_lat);
        end
        held = rep_count;
        @(posedge clk);
        #1 chk({tag, "_hold_valid"}, 32'(thrice_rep_valid), 1);
        chk({tag, "_hold_count"}, 32'(rep_count), 32'(held));
        @(negedge clk);
        clear_sample = 1'b1;
        @(posedge clk);
        #1 clear_sample = 1'b0;
        chk({tag, "_clr_valid"}, 32'(thrice_rep_valid), 0);
        chk({tag, "_clr_thrice"}, 32'(thrice_rep), 0);
        chk({tag, "_clr_busy"}, 32'(busy), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(thrice_rep_valid), 0);
        chk("rst_count", 32'(rep_count), 0);
        chk("rst_thrice", 32'(thrice_rep), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) filler(i);

        query("d0", 0, 0, CM_A, 0, 1, 1);

        wr(0, CM_A, BRD_A); wr(2, CM_A, BRD_A); wr(4, CM_A, BRD_A);
        query("even3", 6, 10, CM_A, 2, 1, 5);

        filler(0); filler(2); filler(4);
        wr(1, CM_A, BRD_A); wr(3, CM_A, BRD_A); wr(5, CM_A, BRD_A);
        query("odd", 6, 10, CM_A, 0, 6, 6);

        filler(1); filler(3); filler(5);
        wr(0, CM_A, BRD_A); wr(4, CM_A, BRD_A);
        query("window", 6, 3, CM_A, 1, 5, 5);

        filler(0); wr(2, CM_A, BRD_A);
        query("castle", 6, 10, 4'hA, 0, 6, 6);

        filler(2); filler(4); wr(6, CM_A, BRD_A);
        query("deep", 8, 10, CM_A, 1, 7, 7);

        filler(6);
        wr(0, CM_A, BRD_A); wr(2, CM_A, BRD_A); wr(4, CM_A, BRD_A);
        start(6, 10, CM_A, BRD_A);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(thrice_rep_valid), 0);
        chk("midrst_count", 32'(rep_count), 0);
        @(negedge clk);
        reset = 1'b0;
        query("after_rst", 6, 10, CM_A, 2, 1, 5);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
